// File: rtl/reg_bus_pkg.sv
// Shared definitions for the register-bus master.
// Contents: FSM state encoding, default phase timings, the register-address
// map of the attached register block, and a helper that formats a 5-bit
// register select as an 8-bit bus word.
package reg_bus_pkg;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    A_SETUP = 4'd1,
    A_PULSE = 4'd2,
    A_HOLD  = 4'd3,
    D_SETUP = 4'd4,
    D_PULSE = 4'd5,
    D_HOLD  = 4'd6,
    RD_WAIT = 4'd7,
    RESP    = 4'd8
  } state_e;

  localparam int unsigned DEF_SETUP_CYC   = 1;
  localparam int unsigned DEF_PULSE_CYC   = 2;
  localparam int unsigned DEF_HOLD_CYC    = 1;
  localparam int unsigned DEF_RD_WAIT_CYC = 2;

  // Width of the shared phase down-counter.
  localparam int unsigned TIMER_W = 8;

  // Register map of the attached register block.
  localparam logic [4:0] REG_CTRL   = 5'h00;
  localparam logic [4:0] REG_STATUS = 5'h01;
  localparam logic [4:0] REG_TXDATA = 5'h03;
  localparam logic [4:0] REG_RXDATA = 5'h09;
  localparam logic [4:0] REG_LAST   = 5'h1F;

  // During the address phase the select occupies [4:0] and [7:5] are zero.
  function automatic logic [7:0] addr_word(input logic [4:0] addr);
    return {3'b000, addr};
  endfunction

endpackage

// File: rtl/reg_bus_phase_timer.sv
// Loadable down-counter with a done flag, shared by every timed FSM state.
// Ports:
//   i_clk      clock, rising edge
//   i_rst      synchronous active-high reset (count -> 0)
//   i_load     reload the counter with i_load_val this edge
//   i_load_val value to load (phase length minus one)
//   o_done     high while the count is zero, i.e. the last cycle of a phase
module reg_bus_phase_timer #(
  parameter int unsigned W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_done
);

  logic [W-1:0] r_count;

  // Reload on phase entry, otherwise count down and rest at zero.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - W'(1);
    end else begin
      r_count <= r_count;
    end
  end

  assign o_done = (r_count == '0);

endmodule

// File: rtl/reg_bus_master.sv
// Register-bus master: turns single read/write commands into a multiplexed
// address/data strobe sequence towards a register block, skipping the address
// phase when the target register was the last one addressed.
// Ports:
//   CLK, RST                   clock and synchronous active-high reset
//   CMD_VALID/READY            command handshake (READY only in IDLE)
//   CMD_WRITE/ADDR/DATA        command fields, captured on acceptance
//   CACHE_INV                  invalidates the last-address cache
//   RSP_VALID/RSP_DATA         one-cycle completion pulse, read data (0 for writes)
//   BUS_ADDR_OR_DATA           1 = address phase, 0 = data phase
//   BUS_WRITE                  write strobe
//   BUS_DATA_OUT               bus data / address word
//   BUS_DATA_IN                readback from the register block
module reg_bus_master
  import reg_bus_pkg::*;
#(
  parameter int unsigned SETUP_CYC   = DEF_SETUP_CYC,
  parameter int unsigned PULSE_CYC   = DEF_PULSE_CYC,
  parameter int unsigned HOLD_CYC    = DEF_HOLD_CYC,
  parameter int unsigned RD_WAIT_CYC = DEF_RD_WAIT_CYC
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       CMD_VALID,
  output logic       CMD_READY,
  input  logic       CMD_WRITE,
  input  logic [4:0] CMD_ADDR,
  input  logic [7:0] CMD_DATA,
  input  logic       CACHE_INV,
  output logic       RSP_VALID,
  output logic [7:0] RSP_DATA,
  output logic       BUS_ADDR_OR_DATA,
  output logic       BUS_WRITE,
  output logic [7:0] BUS_DATA_OUT,
  input  logic [7:0] BUS_DATA_IN
);

  state_e             r_state;
  state_e             w_state_next;
  logic               r_cmd_write;
  logic [4:0]         r_cmd_addr;
  logic [7:0]         r_cmd_data;
  logic [4:0]         r_cache_addr;
  logic               r_cache_vld;
  logic               r_bus_aod;
  logic               r_bus_write;
  logic [7:0]         r_bus_data;
  logic               r_rsp_valid;
  logic [7:0]         r_rsp_data;
  logic               w_accept;
  logic               w_hit;
  logic               w_done;
  logic               w_load;
  logic [TIMER_W-1:0] w_load_val;
  logic [4:0]         w_cur_addr;
  logic [7:0]         w_cur_data;
  logic               w_bus_aod_next;
  logic               w_bus_write_next;
  logic [7:0]         w_bus_data_next;

  assign CMD_READY = (r_state == IDLE) && !RST;
  assign w_accept  = CMD_READY && CMD_VALID;
  assign w_hit     = r_cache_vld && (CMD_ADDR == r_cache_addr);

  // On the acceptance edge the capture registers are not loaded yet, so the
  // bus word for the first phase comes straight from the command inputs.
  assign w_cur_addr = (r_state == IDLE) ? CMD_ADDR : r_cmd_addr;
  assign w_cur_data = (r_state == IDLE) ? CMD_DATA : r_cmd_data;

  // Every state change reloads the shared phase timer.
  assign w_load = (w_state_next != r_state);

  reg_bus_phase_timer #(
    .W (TIMER_W)
  ) u_timer (
    .i_clk      (CLK),
    .i_rst      (RST),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_done     (w_done)
  );

  // Next-state logic; timed states advance on the last cycle of their phase.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_hit) begin
            w_state_next = CMD_WRITE ? D_SETUP : RD_WAIT;
          end else begin
            w_state_next = A_SETUP;
          end
        end else begin
          w_state_next = IDLE;
        end
      end
      A_SETUP: w_state_next = w_done ? A_PULSE : A_SETUP;
      A_PULSE: w_state_next = w_done ? A_HOLD  : A_PULSE;
      A_HOLD: begin
        if (w_done) begin
          w_state_next = r_cmd_write ? D_SETUP : RD_WAIT;
        end else begin
          w_state_next = A_HOLD;
        end
      end
      D_SETUP: w_state_next = w_done ? D_PULSE : D_SETUP;
      D_PULSE: w_state_next = w_done ? D_HOLD  : D_PULSE;
      D_HOLD:  w_state_next = w_done ? RESP    : D_HOLD;
      RD_WAIT: w_state_next = w_done ? RESP    : RD_WAIT;
      RESP:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Phase length minus one for the state being entered.
  always_comb begin
    w_load_val = '0;
    case (w_state_next)
      A_SETUP, D_SETUP: w_load_val = TIMER_W'(SETUP_CYC - 1);
      A_PULSE, D_PULSE: w_load_val = TIMER_W'(PULSE_CYC - 1);
      A_HOLD,  D_HOLD:  w_load_val = TIMER_W'(HOLD_CYC - 1);
      RD_WAIT:          w_load_val = TIMER_W'(RD_WAIT_CYC - 1);
      default:          w_load_val = '0;
    endcase
  end

  // Bus values for the upcoming state; registered below so they are glitch-free.
  always_comb begin
    w_bus_aod_next   = 1'b0;
    w_bus_write_next = 1'b0;
    w_bus_data_next  = r_bus_data;
    case (w_state_next)
      A_SETUP, A_HOLD: begin
        w_bus_aod_next  = 1'b1;
        w_bus_data_next = addr_word(w_cur_addr);
      end
      A_PULSE: begin
        w_bus_aod_next   = 1'b1;
        w_bus_write_next = 1'b1;
        w_bus_data_next  = addr_word(w_cur_addr);
      end
      D_SETUP, D_HOLD: begin
        w_bus_data_next = w_cur_data;
      end
      D_PULSE: begin
        w_bus_write_next = 1'b1;
        w_bus_data_next  = w_cur_data;
      end
      default: begin
        w_bus_data_next = r_bus_data;
      end
    endcase
  end

  // State, captured command, registered bus and response outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= IDLE;
      r_cmd_write <= 1'b0;
      r_cmd_addr  <= 5'h00;
      r_cmd_data  <= 8'h00;
      r_bus_aod   <= 1'b0;
      r_bus_write <= 1'b0;
      r_bus_data  <= 8'h00;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= 8'h00;
    end else begin
      r_state     <= w_state_next;
      r_bus_aod   <= w_bus_aod_next;
      r_bus_write <= w_bus_write_next;
      r_bus_data  <= w_bus_data_next;
      r_rsp_valid <= (w_state_next == RESP);
      if (w_accept) begin
        r_cmd_write <= CMD_WRITE;
        r_cmd_addr  <= CMD_ADDR;
        r_cmd_data  <= CMD_DATA;
      end else begin
        r_cmd_write <= r_cmd_write;
        r_cmd_addr  <= r_cmd_addr;
        r_cmd_data  <= r_cmd_data;
      end
      if ((r_state == RD_WAIT) && (w_state_next == RESP)) begin
        r_rsp_data <= BUS_DATA_IN;
      end else if ((r_state == D_HOLD) && (w_state_next == RESP)) begin
        r_rsp_data <= 8'h00;
      end else begin
        r_rsp_data <= r_rsp_data;
      end
    end
  end

  // Last-address cache; an invalidate beats a simultaneous A_HOLD fill.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cache_addr <= 5'h00;
      r_cache_vld  <= 1'b0;
    end else if (CACHE_INV) begin
      r_cache_addr <= r_cache_addr;
      r_cache_vld  <= 1'b0;
    end else if ((r_state == A_HOLD) && w_done) begin
      r_cache_addr <= r_cmd_addr;
      r_cache_vld  <= 1'b1;
    end else begin
      r_cache_addr <= r_cache_addr;
      r_cache_vld  <= r_cache_vld;
    end
  end

  assign BUS_ADDR_OR_DATA = r_bus_aod;
  assign BUS_WRITE        = r_bus_write;
  assign BUS_DATA_OUT     = r_bus_data;
  assign RSP_VALID        = r_rsp_valid;
  assign RSP_DATA         = r_rsp_data;

endmodule

// File: tb/tb_reg_bus_master.sv
// Self-checking bench for reg_bus_master: a table of single commands with
// hand-computed latency / strobe / readback expectations, plus directed
// sequences for mid-transaction reset and back-to-back commands.
module tb_reg_bus_master;

  logic       CLK = 1'b0;
  logic       RST;
  logic       CMD_VALID;
  logic       CMD_READY;
  logic       CMD_WRITE;
  logic [4:0] CMD_ADDR;
  logic [7:0] CMD_DATA;
  logic       CACHE_INV;
  logic       RSP_VALID;
  logic [7:0] RSP_DATA;
  logic       BUS_ADDR_OR_DATA;
  logic       BUS_WRITE;
  logic [7:0] BUS_DATA_OUT;
  logic [7:0] BUS_DATA_IN;

  int n_checks = 0;
  int n_errors = 0;

  always #5 CLK = ~CLK;

  reg_bus_master dut (
    .CLK              (CLK),
    .RST              (RST),
    .CMD_VALID        (CMD_VALID),
    .CMD_READY        (CMD_READY),
    .CMD_WRITE        (CMD_WRITE),
    .CMD_ADDR         (CMD_ADDR),
    .CMD_DATA         (CMD_DATA),
    .CACHE_INV        (CACHE_INV),
    .RSP_VALID        (RSP_VALID),
    .RSP_DATA         (RSP_DATA),
    .BUS_ADDR_OR_DATA (BUS_ADDR_OR_DATA),
    .BUS_WRITE        (BUS_WRITE),
    .BUS_DATA_OUT     (BUS_DATA_OUT),
    .BUS_DATA_IN      (BUS_DATA_IN)
  );

  typedef struct {
    logic       wr;
    logic [4:0] addr;
    logic [7:0] data;
    logic       inv;     // pulse CACHE_INV while idle before the command
    logic [7:0] bus_in;
    int         lat;     // cycle of RSP_VALID counted from the acceptance edge
    int         pulses;  // number of BUS_WRITE pulses
    int         aph;     // cycles with BUS_ADDR_OR_DATA=1
    logic [7:0] rdata;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int   lat    = 0;
    int   pulses = 0;
    int   aph    = 0;
    int   run    = 0;
    logic prev_w = 1'b0;
    logic [7:0] rd = 8'h00;
    @(negedge CLK);
    if (v.inv) begin
      CACHE_INV = 1'b1;
      @(negedge CLK);
      CACHE_INV = 1'b0;
    end
    BUS_DATA_IN = v.bus_in;
    CMD_VALID   = 1'b1;
    CMD_WRITE   = v.wr;
    CMD_ADDR    = v.addr;
    CMD_DATA    = v.data;
    #1;
    chk($sformatf("v%0d_ready", idx), 32'(CMD_READY), 32'd1);
    @(posedge CLK);
    #1;
    // Scramble inputs: the command must already be captured.
    CMD_VALID = 1'b0;
    CMD_WRITE = ~v.wr;
    CMD_ADDR  = ~v.addr;
    CMD_DATA  = ~v.data;
    for (int c = 1; c <= 30; c++) begin
      if (BUS_WRITE) begin
        run++;
        if (!prev_w) pulses++;
        chk($sformatf("v%0d_busdata_c%0d", idx, c), 32'(BUS_DATA_OUT),
            BUS_ADDR_OR_DATA ? 32'(v.addr) : 32'(v.data));
      end else if (prev_w) begin
        chk($sformatf("v%0d_pulse_len", idx), 32'(run), 32'd2);
        run = 0;
      end
      if (BUS_ADDR_OR_DATA) aph++;
      prev_w = BUS_WRITE;
      if (RSP_VALID) begin
        lat = c;
        rd  = RSP_DATA;
        break;
      end
      @(posedge CLK);
      #1;
    end
    chk($sformatf("v%0d_latency", idx), 32'(lat), 32'(v.lat));
    chk($sformatf("v%0d_pulses", idx), 32'(pulses), 32'(v.pulses));
    chk($sformatf("v%0d_addr_cycles", idx), 32'(aph), 32'(v.aph));
    chk($sformatf("v%0d_rsp_data", idx), 32'(rd), 32'(v.rdata));
    @(posedge CLK);
    #1;
    chk($sformatf("v%0d_rsp_one_cycle", idx), 32'(RSP_VALID), 32'd0);
    chk($sformatf("v%0d_back_idle", idx), 32'(CMD_READY), 32'd1);
  endtask

  initial begin
    //        wr    addr   data   inv   bus_in lat pul aph rdata
    vecs[0] = '{1'b1, 5'h03, 8'h5A, 1'b0, 8'h00, 9, 2, 4, 8'h00}; // first write, miss
    vecs[1] = '{1'b1, 5'h03, 8'h11, 1'b0, 8'h00, 5, 1, 0, 8'h00}; // same addr, hit
    vecs[2] = '{1'b0, 5'h09, 8'h00, 1'b0, 8'h1F, 7, 1, 4, 8'h1F}; // read, miss
    vecs[3] = '{1'b0, 5'h09, 8'h00, 1'b0, 8'h2C, 3, 0, 0, 8'h2C}; // read, hit
    vecs[4] = '{1'b1, 5'h03, 8'h22, 1'b0, 8'h00, 9, 2, 4, 8'h00}; // cache holds 09
    vecs[5] = '{1'b1, 5'h03, 8'h33, 1'b1, 8'h00, 9, 2, 4, 8'h00}; // invalidated first
    vecs[6] = '{1'b0, 5'h03, 8'h00, 1'b0, 8'h80, 3, 0, 0, 8'h80}; // read, hit
    vecs[7] = '{1'b1, 5'h1F, 8'hFF, 1'b0, 8'h00, 9, 2, 4, 8'h00}; // top address
    vecs[8] = '{1'b0, 5'h1F, 8'h00, 1'b0, 8'hA5, 3, 0, 0, 8'hA5}; // read, hit

    RST = 1'b1; CMD_VALID = 1'b0; CMD_WRITE = 1'b0; CMD_ADDR = 5'h00;
    CMD_DATA = 8'h00; CACHE_INV = 1'b0; BUS_DATA_IN = 8'h00;

    // Reset state.
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_ready", 32'(CMD_READY), 32'd0);
    chk("rst_bus_write", 32'(BUS_WRITE), 32'd0);
    chk("rst_bus_aod", 32'(BUS_ADDR_OR_DATA), 32'd0);
    chk("rst_bus_data", 32'(BUS_DATA_OUT), 32'd0);
    chk("rst_rsp_valid", 32'(RSP_VALID), 32'd0);
    chk("rst_rsp_data", 32'(RSP_DATA), 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    chk("post_rst_ready", 32'(CMD_READY), 32'd1);

    for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

    // Reset during D_PULSE of a cache-hit write to 0x1F.
    begin
      int rsp_cnt = 0;
      @(negedge CLK);
      CMD_VALID = 1'b1; CMD_WRITE = 1'b1; CMD_ADDR = 5'h1F; CMD_DATA = 8'h44;
      @(posedge CLK);
      #1;
      CMD_VALID = 1'b0;
      chk("mrst_dsetup_aod", 32'(BUS_ADDR_OR_DATA), 32'd0);
      @(posedge CLK);
      #1;
      chk("mrst_dpulse_write", 32'(BUS_WRITE), 32'd1);
      chk("mrst_dpulse_data", 32'(BUS_DATA_OUT), 32'h44);
      @(negedge CLK);
      RST = 1'b1;
      @(posedge CLK);
      #1;
      chk("mrst_write_low", 32'(BUS_WRITE), 32'd0);
      chk("mrst_bus_data", 32'(BUS_DATA_OUT), 32'd0);
      chk("mrst_rsp_valid", 32'(RSP_VALID), 32'd0);
      chk("mrst_ready_in_rst", 32'(CMD_READY), 32'd0);
      @(negedge CLK);
      RST = 1'b0;
      for (int c = 0; c < 12; c++) begin
        @(posedge CLK);
        #1;
        if (RSP_VALID) rsp_cnt++;
      end
      chk("mrst_no_response", 32'(rsp_cnt), 32'd0);
      run_vec('{1'b1, 5'h1F, 8'h55, 1'b0, 8'h00, 9, 2, 4, 8'h00}, 100);
    end

    // CMD_VALID held high across three commands with fields changing each cycle.
    begin
      int         acc = 0;
      int         rsp = 0;
      logic [4:0] a_acc = 5'h00;
      logic [7:0] d_acc = 8'h00;
      CMD_VALID = 1'b1;
      CMD_WRITE = 1'b1;
      for (int cyc = 0; cyc < 80 && rsp < 3; cyc++) begin
        @(negedge CLK);
        CMD_ADDR = 5'(cyc * 3 + 1);
        CMD_DATA = 8'(cyc * 13 + 5);
        #1;
        if (BUS_ADDR_OR_DATA)
          chk("b2b_addr", 32'(BUS_DATA_OUT), 32'(a_acc));
        else if (BUS_WRITE)
          chk("b2b_data", 32'(BUS_DATA_OUT), 32'(d_acc));
        if (RSP_VALID) rsp++;
        if (CMD_READY) begin
          chk("b2b_idle_write", 32'(BUS_WRITE), 32'd0);
          if (acc < 3) begin
            a_acc = CMD_ADDR;
            d_acc = CMD_DATA;
            acc++;
          end else begin
            CMD_VALID = 1'b0;
          end
        end
      end
      @(negedge CLK);
      CMD_VALID = 1'b0;
      chk("b2b_accepted", 32'(acc), 32'd3);
      chk("b2b_responses", 32'(rsp), 32'd3);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
